btn_scan_scheduler: RTL and testbench
=====================================

BTN_SCAN_SCHEDULER -- requirements
Module: btn_scan_scheduler

Interface
REQ-001 SHALL have parameter NBTN, default 4: number of buttons sharing one debounce timer, range 2..16.
REQ-002 SHALL have parameter TIME_PERIOD, default 75000: stability window in clocks, range 1..65535.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_btn, input, NBTN bits: raw button levels.
REQ-006 SHALL have port o_debounced, output, NBTN bits: debounced button levels.
REQ-007 SHALL have port o_event_valid, output, 1 bit: an event is pending.
REQ-008 SHALL have port i_event_ready, input, 1 bit: consumer accepts the event.
REQ-009 SHALL have port o_event_idx, output, clog2(NBTN) bits: index of the button that changed.
REQ-010 SHALL have port o_event_press, output, 1 bit: new level of that button (1 = press, 0 = release).

Function
REQ-011 SHALL pass i_btn through a per-bit 2-flop synchronizer to form vector s_btn (see REQ-028).
REQ-012 SHALL own exactly one 16-bit countdown timer, granted to one button at a time.
REQ-013 SHALL implement three states: SCAN, TIMING, COMMIT.
REQ-014 SCAN: search s_btn != o_debounced round-robin, starting at pointer rr; on first mismatch latch idx, load timer = TIME_PERIOD-1, go to TIMING in the same cycle; with no mismatch, stay in SCAN.
REQ-015 TIMING: if s_btn[idx] == o_debounced[idx] (bounce back), abort to SCAN and set rr = idx+1 mod NBTN.
REQ-016 TIMING: else if timer == 0, go to COMMIT; else decrement timer; TIMING therefore lasts exactly TIME_PERIOD cycles for a stable input.
REQ-017 COMMIT: when o_event_valid == 0 or i_event_ready == 1, toggle o_debounced[idx], load o_event_idx = idx, o_event_press = new level, set o_event_valid, set rr = idx+1 mod NBTN, go to SCAN.
REQ-018 COMMIT: otherwise hold, with o_debounced unchanged and the timer not reloaded.
REQ-019 In COMMIT, REQ-017 SHALL NOT re-check s_btn; the window already qualified the change.
REQ-020 o_event_valid SHALL clear on o_event_valid && i_event_ready unless REQ-017 reloads it in the same cycle.
REQ-021 While o_event_valid is high and i_event_ready is low, o_event_idx and o_event_press SHALL be stable.
REQ-022 Latency from a clean stable edge on an idle block to o_event_valid SHALL be 2 (sync) + 1 (SCAN) + TIME_PERIOD + 1 (COMMIT) cycles.
REQ-023 Only one button is timed at a time; other mismatches wait; no change is ever lost while its level persists.
REQ-024 NBTN not a power of 2: rr wrap SHALL skip indices >= NBTN.

Reset
REQ-025 i_reset_n low SHALL immediately force: synchronizer 0, o_debounced 0, timer 0, rr 0, state SCAN, o_event_valid 0, o_event_idx 0, o_event_press 0.
REQ-026 Reset asserted mid-TIMING or mid-COMMIT SHALL discard the pending change with no event emitted.
REQ-027 After reset release, a button held high SHALL be re-qualified through the full window.

Configuration
REQ-028 Macro BTN_SYNC_EN defined: the 2-flop synchronizer SHALL be present; undefined: s_btn = i_btn directly, and REQ-022 latency drops by 2 cycles.

Verification (TIME_PERIOD = 8, NBTN = 4, i_event_ready = 1 unless stated)
REQ-029 Clean press on btn2 held -> o_debounced[2] = 1 and event {idx 2, press 1} 12 cycles after the edge (10 without BTN_SYNC_EN).
REQ-030 btn1 pulse high 5 cycles, then low -> abort, no event, o_debounced stays 0.
REQ-031 btn0 and btn3 rise in the same cycle -> event idx 0 after 12 cycles, then idx 3 at 22 cycles (REQ-014 reload + 8 + COMMIT).
REQ-032 i_event_ready low, two qualified changes -> first event held stable, second waits in COMMIT with o_debounced unchanged; raising ready -> both delivered in order.
REQ-033 i_reset_n pulsed low at TIMING cycle 4 -> all outputs 0 at once, no event; with input still high, event 12 cycles after release.

Source files
------------

// File: rtl/btn_scan_scheduler.sv
// btn_scan_scheduler: debounces NBTN buttons with one shared 16-bit stability
// timer. A round-robin scanner hands the timer to one changed button at a time.
// Each qualified change toggles o_debounced and is reported on a valid/ready
// event port.
// Optional feature: define BTN_SYNC_EN to add a 2-flop input synchronizer.
// Without it the raw inputs feed the scanner directly, and latency is 2 cycles
// shorter.
module btn_scan_scheduler #(
  parameter int NBTN        = 4,
  parameter int TIME_PERIOD = 75000
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NBTN-1:0]         i_btn,
  output logic [NBTN-1:0]         o_debounced,
  output logic                    o_event_valid,
  input  logic                    i_event_ready,
  output logic [$clog2(NBTN)-1:0] o_event_idx,
  output logic                    o_event_press
);
  localparam int              IDXW       = $clog2(NBTN);
  localparam logic [15:0]     TIMER_LOAD = 16'(TIME_PERIOD - 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NBTN - 1);
  localparam logic [IDXW:0]   NBTN_W     = (IDXW + 1)'(NBTN);

  typedef enum logic [1:0] {SCAN, TIMING, COMMIT} state_t;

  logic [NBTN-1:0] w_s_btn;

`ifdef BTN_SYNC_EN
  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;

  // Two-flop synchronizer for the asynchronous button levels
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_btn = r_sync2;
`else
  assign w_s_btn = i_btn;
`endif

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_rr;
  logic [15:0]     r_timer;
  logic [NBTN-1:0] r_debounced;
  logic            r_event_valid;
  logic [IDXW-1:0] r_event_idx;
  logic            r_event_press;

  logic [NBTN-1:0] w_mismatch;
  logic            w_found;
  logic [IDXW-1:0] w_first;
  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_j;

  assign w_mismatch = w_s_btn ^ r_debounced;

  // Wrap an index to the next button. Indices at or beyond NBTN are never produced.
  function automatic logic [IDXW-1:0] f_next(input logic [IDXW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
  endfunction

  // Round-robin pick of the first mismatching button at or after r_rr
  always_comb begin
    w_found = 1'b0;
    w_first = '0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NBTN; k++) begin
      w_sum = {1'b0, r_rr} + (IDXW + 1)'(k);
      if (w_sum >= NBTN_W) begin
        w_sum = w_sum - NBTN_W;
      end
      w_j = w_sum[IDXW-1:0];
      if (!w_found && w_mismatch[w_j]) begin
        w_found = 1'b1;
        w_first = w_j;
      end
    end
  end

  // Scheduler FSM: scan, time one button's stability window, commit the toggle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= SCAN;
      r_idx         <= '0;
      r_rr          <= '0;
      r_timer       <= '0;
      r_debounced   <= '0;
      r_event_valid <= 1'b0;
      r_event_idx   <= '0;
      r_event_press <= 1'b0;
    end else begin
      // A consumed event drops unless a commit below reloads it this cycle
      if (r_event_valid && i_event_ready) begin
        r_event_valid <= 1'b0;
      end
      case (r_state)
        SCAN: begin
          if (w_found) begin
            r_idx   <= w_first;
            r_timer <= TIMER_LOAD;
            r_state <= TIMING;
          end
        end
        TIMING: begin
          if (w_s_btn[r_idx] == r_debounced[r_idx]) begin
            // Bounced back before the window closed: give the next button a turn
            r_state <= SCAN;
            r_rr    <= f_next(r_idx);
          end else if (r_timer == 16'd0) begin
            r_state <= COMMIT;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        COMMIT: begin
          // The window already qualified the level; only the event slot matters here
          if (!r_event_valid || i_event_ready) begin
            r_debounced[r_idx] <= ~r_debounced[r_idx];
            r_event_idx        <= r_idx;
            r_event_press      <= ~r_debounced[r_idx];
            r_event_valid      <= 1'b1;
            r_rr               <= f_next(r_idx);
            r_state            <= SCAN;
          end
        end
        default: begin
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign o_debounced   = r_debounced;
  assign o_event_valid = r_event_valid;
  assign o_event_idx   = r_event_idx;
  assign o_event_press = r_event_press;

endmodule

// File: tb/tb_btn_scan_scheduler.sv
// Self-checking bench for btn_scan_scheduler (NBTN=4, TIME_PERIOD=8).
// Directed vector table, hand-written multi-cycle sequences, then randomized
// bouncing inputs checked against debounce rules stated at event level.
module tb_btn_scan_scheduler;
  localparam int NBTN = 4;
  localparam int TP   = 8;
`ifdef BTN_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  // Cycles from an input edge on an idle block to the event
  localparam int L = S + 1 + TP + 1;
  // Extra cycles for a second, already-waiting change: SCAN + window + COMMIT
  localparam int D = TP + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic       ready = 1'b1;
  logic [3:0] deb;
  logic       vld;
  logic [1:0] idx;
  logic       press;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_scan_scheduler #(.NBTN(NBTN), .TIME_PERIOD(TP)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_btn         (btn),
    .o_debounced   (deb),
    .o_event_valid (vld),
    .i_event_ready (ready),
    .o_event_idx   (idx),
    .o_event_press (press)
  );

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         ncyc;
    logic [3:0] edeb;
    logic       evld;
    logic [1:0] eidx;
    logic       epress;
  } vec_t;

  vec_t tbl[11];

  // Random-phase state
  logic [3:0] hist[$];
  logic [3:0] pdeb, diff;
  logic       pvld, ppress, crdy, ok, found;
  logic [1:0] pidx;
  int         last_c, run;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] edeb, input logic evld,
                     input logic [1:0] eidx, input logic epress);
    n_cmp++;
    if (deb !== edeb || vld !== evld || idx !== eidx || press !== epress) begin
      n_bad++;
      $display("FAIL %s: got deb=%b vld=%b idx=%0d press=%b, want deb=%b vld=%b idx=%0d press=%b",
               name, deb, vld, idx, press, edeb, evld, eidx, epress);
    end
  endtask

  // Scanner's view of button b at edge e (inputs were 0 before the random phase)
  function automatic logic s_at(input int e, input int b);
    if (e - S < 0) return 1'b0;
    return hist[e-S][b];
  endfunction

  initial begin
    tbl[0]  = '{4'b1001, 1'b1, L-1, 4'b0000, 1'b0, 2'd0, 1'b0}; // btn0+btn3 rise together
    tbl[1]  = '{4'b1001, 1'b1, 1,   4'b0001, 1'b1, 2'd0, 1'b1}; // idx0 first
    tbl[2]  = '{4'b1001, 1'b1, D-1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{4'b1001, 1'b1, 1,   4'b1001, 1'b1, 2'd3, 1'b1}; // idx3 second
    tbl[4]  = '{4'b1101, 1'b1, L-1, 4'b1001, 1'b0, 2'd3, 1'b1}; // clean press btn2
    tbl[5]  = '{4'b1101, 1'b1, 1,   4'b1101, 1'b1, 2'd2, 1'b1};
    tbl[6]  = '{4'b1101, 1'b1, 1,   4'b1101, 1'b0, 2'd2, 1'b1}; // accepted, valid drops
    tbl[7]  = '{4'b1111, 1'b1, 5,   4'b1101, 1'b0, 2'd2, 1'b1}; // btn1 5-cycle pulse
    tbl[8]  = '{4'b1101, 1'b1, 20,  4'b1101, 1'b0, 2'd2, 1'b1}; // aborted, no event
    tbl[9]  = '{4'b1001, 1'b1, L,   4'b1001, 1'b1, 2'd2, 1'b0}; // release btn2
    tbl[10] = '{4'b1001, 1'b1, 1,   4'b1001, 1'b0, 2'd2, 1'b0};

    // Reset state while reset is held from time zero
    #1;
    chk("reset_state", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      btn   = tbl[i].btn;
      ready = tbl[i].rdy;
      tick(tbl[i].ncyc);
      chk($sformatf("vec%0d", i), tbl[i].edeb, tbl[i].evld, tbl[i].eidx, tbl[i].epress);
    end

    // Backpressure: two changes, consumer stalled
    ready = 1'b0;
    btn   = 4'b1010;
    tick(L);
    chk("bp_first", 4'b1000, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3 * L; i++) begin
      tick(1);
      chk($sformatf("bp_hold%0d", i), 4'b1000, 1'b1, 2'd0, 1'b0);
    end
    ready = 1'b1;
    tick(1);
    chk("bp_second", 4'b1010, 1'b1, 2'd1, 1'b1);
    tick(1);
    chk("bp_drain", 4'b1010, 1'b0, 2'd1, 1'b1);

    // Asynchronous reset mid-cycle clears everything at once
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 1'b0, 2'd0, 1'b0);
    btn = 4'b0001;
    tick(2);
    rst_n = 1'b1;
    tick(S + 1 + 4);
    chk("rst_timing", 4'b0000, 1'b0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(2);
    chk("rst_held", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(L - 1);
    chk("requal_early", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(1);
    chk("requal", 4'b0001, 1'b1, 2'd0, 1'b1);

    // Randomized bouncing inputs with random backpressure
    #2 rst_n = 1'b0;
    btn = 4'b0000;
    tick(2);
    rst_n  = 1'b1;
    pdeb   = 4'b0000;
    pvld   = 1'b0;
    pidx   = 2'd0;
    ppress = 1'b0;
    last_c = -1;
    hist.delete();
    for (int c = 0; c < 3200; c++) begin
      if (c < 3000) begin
        for (int b = 0; b < NBTN; b++) begin
          if ($urandom_range(0, 39) == 0) btn[b] = ~btn[b];
        end
        ready = ($urandom_range(0, 2) != 0);
      end else begin
        ready = 1'b1;
      end
      crdy = ready;
      tick(1);
      hist.push_back(btn);
      n_cmp++;
      if (deb !== pdeb) begin
        diff = deb ^ pdeb;
        ok = $onehot(diff) && (vld === 1'b1) && diff[idx] && (press === deb[idx]) && (!pvld || crdy);
        if (ok) begin
          run   = 0;
          found = 1'b0;
          for (int e2 = last_c + 1; e2 <= c - 1; e2++) begin
            if (s_at(e2, int'(idx)) == press) run++;
            else run = 0;
            if (run >= TP + 1) found = 1'b1;
          end
          ok = found;
        end
        if (!ok) begin
          n_bad++;
          $display("FAIL rnd_commit edge %0d: got deb %b->%b vld=%b idx=%0d press=%b, want one toggled bit reported after a stable %0d-edge window",
                   c, pdeb, deb, vld, idx, press, TP + 1);
        end
        last_c = c;
      end else if (pvld && !crdy) begin
        if (!(vld === 1'b1 && idx === pidx && press === ppress)) begin
          n_bad++;
          $display("FAIL rnd_hold edge %0d: got vld=%b idx=%0d press=%b, want vld=1 idx=%0d press=%b",
                   c, vld, idx, press, pidx, ppress);
        end
      end else begin
        if (vld !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_idle edge %0d: got vld=%b, want 0", c, vld);
        end
      end
      pdeb   = deb;
      pvld   = vld;
      pidx   = idx;
      ppress = press;
    end
    n_cmp++;
    if (deb !== btn) begin
      n_bad++;
      $display("FAIL rnd_settle: got deb=%b, want %b", deb, btn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
